// File: rtl/block_fill_mem.sv
// block_fill_mem: block-organised word store with fixed-latency burst reads.
// A read returns a whole block as BLOCK_SIZE consecutive beats after LATENCY
// wait cycles; a write updates one word and pulses wr_ack the next cycle.
// Optional macro BLOCK_FILL_WRAP_EN: critical-word-first beat ordering
// (start at the requested offset and wrap). Without it beats run 0..N-1.
module block_fill_mem #(
    parameter int DATA_WIDTH   = 16,
    parameter int TAG_WIDTH    = 16,
    parameter int BLOCK_SIZE   = 4,
    parameter int OFFSET_WIDTH = 2,
    parameter int LATENCY      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    input  logic [OFFSET_WIDTH-1:0] req_offset,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [OFFSET_WIDTH-1:0] rsp_offset,
    output logic                    rsp_last,
    output logic                    wr_ack,
    output logic [31:0]             read_count
);

    localparam int DEPTH  = BLOCK_SIZE << TAG_WIDTH;
    localparam int ADDR_W = TAG_WIDTH + OFFSET_WIDTH;

    // Final WAIT count and final beat index; the LATENCY=0 branch never
    // enters WAIT, so its WAIT_LAST value is irrelevant.
    localparam logic [3:0]              WAIT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [OFFSET_WIDTH-1:0] BEAT_LAST = OFFSET_WIDTH'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    // Request fields captured on a read accept.
    typedef struct packed {
        logic [TAG_WIDTH-1:0]    tag;
        logic [OFFSET_WIDTH-1:0] offset;
    } rd_req_t;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    state_t                  state_q, state_d;
    rd_req_t                 lat_q;
    logic [3:0]              wait_cnt_q;
    logic [OFFSET_WIDTH-1:0] beat_cnt_q;
    logic [OFFSET_WIDTH-1:0] beat_off;
    logic                    wr_ack_q;
    logic [31:0]             read_count_q;

    logic idle;
    logic rd_accept;
    logic wr_accept;

    // Acceptance decodes from the registered state only, so req_ready never
    // depends combinationally on the request inputs.
    assign idle      = (state_q == IDLE);
    assign rd_accept = idle && req_valid && !req_write;
    assign wr_accept = idle && req_valid && req_write;

`ifdef BLOCK_FILL_WRAP_EN
    // Critical word first: modulo-BLOCK_SIZE wrap falls out of the width.
    assign beat_off = lat_q.offset + beat_cnt_q;
`else
    assign beat_off = beat_cnt_q;
`endif

    assign wr_ack     = wr_ack_q;
    assign read_count = read_count_q;

    // Next-state and output decode; outputs are zero outside a beat.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_last   = 1'b0;
        rsp_offset = '0;
        rsp_data   = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (rd_accept) begin
                    state_d = (LATENCY > 0) ? WAIT : BURST;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                rsp_valid  = 1'b1;
                rsp_offset = beat_off;
                // Read the store live so earlier writes are always visible.
                rsp_data   = mem[ADDR_W'({lat_q.tag, beat_off})];
                rsp_last   = (beat_cnt_q == BEAT_LAST);
                if (beat_cnt_q == BEAT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, latched request and write-ack pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            wait_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            wr_ack_q     <= 1'b0;
            read_count_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ack_q <= wr_accept;
            if (rd_accept) begin
                lat_q.tag    <= req_tag;
                lat_q.offset <= req_offset;
                read_count_q <= read_count_q + 32'd1;
                wait_cnt_q   <= '0;
                beat_cnt_q   <= '0;
            end
            if (state_q == WAIT) begin
                wait_cnt_q <= wait_cnt_q + 4'd1;
            end
            // Wraps back to zero on the last beat, ready for the next read.
            if (state_q == BURST) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    // Word store; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_accept && !reset) begin
            mem[ADDR_W'({req_tag, req_offset})] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_block_fill_mem.sv
// Bench for block_fill_mem: table-driven cycle vectors on a LATENCY=4
// instance plus hand sequences for reset mid-burst and a LATENCY=0 instance.
module tb_block_fill_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_tag;
    logic [1:0]  req_offset;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_last, wr_ack;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_offset;
    logic [31:0] read_count;

    logic        z_req_valid, z_req_ready, z_req_write;
    logic [15:0] z_req_tag;
    logic [1:0]  z_req_offset;
    logic [15:0] z_req_wdata;
    logic        z_rsp_valid, z_rsp_last, z_wr_ack;
    logic [15:0] z_rsp_data;
    logic [1:0]  z_rsp_offset;
    logic [31:0] z_read_count;

    block_fill_mem #(.DATA_WIDTH(16), .TAG_WIDTH(16), .BLOCK_SIZE(4),
                     .OFFSET_WIDTH(2), .LATENCY(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_tag(req_tag), .req_offset(req_offset), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_offset(rsp_offset),
        .rsp_last(rsp_last), .wr_ack(wr_ack), .read_count(read_count)
    );

    block_fill_mem #(.DATA_WIDTH(16), .TAG_WIDTH(16), .BLOCK_SIZE(4),
                     .OFFSET_WIDTH(2), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_tag(z_req_tag), .req_offset(z_req_offset), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_data(z_rsp_data), .rsp_offset(z_rsp_offset),
        .rsp_last(z_rsp_last), .wr_ack(z_wr_ack), .read_count(z_read_count)
    );

    int tests = 0;
    int fails = 0;

    // exp packing: {ready, valid, last, ack, offset[1:0], data[15:0]}
    typedef struct {
        logic        valid;
        logic        write;
        logic [15:0] tag;
        logic [1:0]  off;
        logic [15:0] wdata;
        logic [21:0] exp;
    } vec_t;

    function automatic logic [21:0] ex(logic rdy, logic v, logic l, logic a,
                                       logic [1:0] o, logic [15:0] d);
        return {rdy, v, l, a, o, d};
    endfunction

    function automatic vec_t mk(logic valid, logic write, logic [15:0] tag,
                                logic [1:0] off, logic [15:0] wdata, logic [21:0] e);
        vec_t r;
        r.valid = valid; r.write = write; r.tag = tag;
        r.off = off; r.wdata = wdata; r.exp = e;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] obs();
        return {req_ready, rsp_valid, rsp_last, wr_ack, rsp_offset, rsp_data};
    endfunction

    function automatic logic [21:0] zobs();
        return {z_req_ready, z_rsp_valid, z_rsp_last, z_wr_ack, z_rsp_offset, z_rsp_data};
    endfunction

    vec_t vq[$];

    initial begin
        logic [1:0] o;
        logic       seen;

        reset = 1'b1;
        req_valid = 0; req_write = 0; req_tag = '0; req_offset = '0; req_wdata = '0;
        z_req_valid = 0; z_req_write = 0; z_req_tag = '0; z_req_offset = '0; z_req_wdata = '0;

        for (int i = 0; i < (1 << 18); i++) dut.mem[18'(i)] = 16'(i);
        for (int j = 0; j < 4; j++) begin
            dut0.mem[18'(5 * 4 + j)] = 16'h0050 + 16'(j);
            dut0.mem[18'(6 * 4 + j)] = 16'h0060 + 16'(j);
        end

        repeat (2) tick();
        check("reset_outputs", 32'(obs()), 32'(ex(1, 0, 0, 0, 0, 0)));
        check("reset_read_count", read_count, 32'd0);
        reset = 1'b0;

        // Basic read of tag 0x42BB offset 2; writes offered while busy are ignored.
        vq.push_back(mk(1, 0, 16'h42BB, 2'd2, 16'h0, ex(1, 0, 0, 0, 0, 0)));
        for (int w = 0; w < 4; w++)
            vq.push_back(mk(1, 1, 16'h42BB, 2'd0, 16'hDEAD, ex(0, 0, 0, 0, 0, 0)));
        for (int k = 0; k < 4; k++) begin
`ifdef BLOCK_FILL_WRAP_EN
            o = 2'(2 + k);
`else
            o = 2'(k);
`endif
            vq.push_back(mk(0, 0, 16'h0, 2'd0, 16'h0,
                            ex(0, 1, k == 3, 0, o, 16'h0AEC + 16'(o))));
        end
        // Write 0xBEEF to tag 1 offset 3, then read tag 1 during the ack cycle.
        vq.push_back(mk(1, 1, 16'h0001, 2'd3, 16'hBEEF, ex(1, 0, 0, 0, 0, 0)));
        vq.push_back(mk(1, 0, 16'h0001, 2'd0, 16'h0, ex(1, 0, 0, 1, 0, 0)));
        for (int w = 0; w < 4; w++)
            vq.push_back(mk(0, 0, 16'h0, 2'd0, 16'h0, ex(0, 0, 0, 0, 0, 0)));
        for (int k = 0; k < 4; k++)
            vq.push_back(mk(0, 0, 16'h0, 2'd0, 16'h0,
                            ex(0, 1, k == 3, 0, 2'(k), (k < 3) ? 16'h0004 + 16'(k) : 16'hBEEF)));
        vq.push_back(mk(0, 0, 16'h0, 2'd0, 16'h0, ex(1, 0, 0, 0, 0, 0)));

        foreach (vq[i]) begin
            check($sformatf("vec%0d", i), 32'(obs()), 32'(vq[i].exp));
            req_valid  = vq[i].valid;
            req_write  = vq[i].write;
            req_tag    = vq[i].tag;
            req_offset = vq[i].off;
            req_wdata  = vq[i].wdata;
            tick();
        end
        check("read_count_after_table", read_count, 32'd2);

        // Reset taking effect right after the second beat.
        req_valid = 1; req_write = 0; req_tag = 16'h42BB; req_offset = 2'd0;
        tick();
        req_valid = 0;
        repeat (4) tick();
        check("rst_beat0", 32'(obs()), 32'(ex(0, 1, 0, 0, 2'd0, 16'h0AEC)));
        tick();
        check("rst_beat1", 32'(obs()), 32'(ex(0, 1, 0, 0, 2'd1, 16'h0AED)));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_after_outputs", 32'(obs()), 32'(ex(1, 0, 0, 0, 0, 0)));
        check("rst_after_read_count", read_count, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            seen = seen | rsp_valid | rsp_last;
            tick();
        end
        check("rst_no_more_beats", 32'(seen), 32'd0);

        // Preloaded data survives reset.
        req_valid = 1; req_tag = 16'h42BB; req_offset = 2'd0;
        tick();
        req_valid = 0;
        repeat (4) tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("post_rst_beat%0d", k), 32'(obs()),
                  32'(ex(0, 1, k == 3, 0, 2'(k), 16'h0AEC + 16'(k))));
            tick();
        end
        check("post_rst_read_count", read_count, 32'd1);

        // LATENCY=0, req_valid held through two reads.
        z_req_valid = 1; z_req_write = 0; z_req_tag = 16'h0005; z_req_offset = 2'd0;
        check("z_idle_ready", 32'(zobs()), 32'(ex(1, 0, 0, 0, 0, 0)));
        tick();
        z_req_tag = 16'h0006;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("z_rd1_beat%0d", k), 32'(zobs()),
                  32'(ex(0, 1, k == 3, 0, 2'(k), 16'h0050 + 16'(k))));
            tick();
        end
        check("z_ready_after_last", 32'(zobs()), 32'(ex(1, 0, 0, 0, 0, 0)));
        check("z_count_one", z_read_count, 32'd1);
        tick();
        z_req_valid = 0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("z_rd2_beat%0d", k), 32'(zobs()),
                  32'(ex(0, 1, k == 3, 0, 2'(k), 16'h0060 + 16'(k))));
            tick();
        end
        check("z_idle_end", 32'(zobs()), 32'(ex(1, 0, 0, 0, 0, 0)));
        check("z_count_two", z_read_count, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
